// File: rtl/alu_pkg.sv
// Shared ALU types: control codes, response-slot state and legality check.
package alu_pkg;

   typedef enum logic [2:0] {
      ADD = 3'b000,
      SUB = 3'b001,
      AND = 3'b010,
      OR  = 3'b011,
      SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_e;

   // Codes 100, 110 and 111 are reserved and flagged as errors.
   function automatic logic is_legal_ctrl(input logic [2:0] ctrl);
      case (ctrl)
         ADD, SUB, AND, OR, SLT: return 1'b1;
         default:                return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Request/response bundle between the issue logic and the shared-ALU arbiter.
interface alu_share_arbiter_if #(
   parameter int NREQ = 2,
   parameter int DW   = 32,
   parameter int CNTW = 16
);
   localparam int SRCW = $clog2(NREQ);

   logic [NREQ-1:0]    req_valid;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*DW-1:0] req_op1;
   logic [NREQ*DW-1:0] req_op2;
   logic [NREQ*3-1:0]  req_ctrl;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [DW-1:0]      rsp_data;
   logic               rsp_eq;
   logic               rsp_err;
   logic [SRCW-1:0]    rsp_src;
   logic [CNTW-1:0]    op_count;

   // Issue side: drives requests, consumes responses.
   modport master (
      output req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_eq, rsp_err, rsp_src, op_count
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_op1, req_op2, req_ctrl, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_eq, rsp_err, rsp_src, op_count
   );

endinterface

// File: rtl/alu_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, modulo NREQ.
module alu_rr_picker #(
   parameter int NREQ = 2,
   parameter int IW   = $clog2(NREQ)
) (
   input  logic            en,
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IW-1:0]   idx,
   output logic            any
);

   // Walk the rotation order from ptr; the first hit wins and blocks the rest.
   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      if (en) begin
         for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
               if (!any && req[i] && (i == (int'(ptr) + k) % NREQ)) begin
                  gnt[i] = 1'b1;
                  idx    = IW'(i);
                  any    = 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one ALU among NREQ requesters with round-robin grant and a
// single registered response slot (1-cycle latency, held under backpressure).
//
//   state      | meaning
//   SLOT_EMPTY | no response pending; any valid requester may issue
//   SLOT_FULL  | response on rsp_*; refill only in the cycle it drains
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int DW   = 32,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   alu_share_arbiter_if.slave bus
);

   localparam int SRCW = $clog2(NREQ);

   slot_e            slot_q, slot_d;
   logic [DW-1:0]    rsp_data_q, rsp_data_d;
   logic             rsp_eq_q, rsp_eq_d;
   logic             rsp_err_q, rsp_err_d;
   logic [SRCW-1:0]  rsp_src_q, rsp_src_d;
   logic [SRCW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CNTW-1:0]  op_count_q, op_count_d;

   logic             can_issue;
   logic             issue;
   logic [NREQ-1:0]  gnt;
   logic [SRCW-1:0]  gnt_idx;
   logic [DW-1:0]    alu_a, alu_b, alu_res;
   logic [2:0]       alu_ctrl;
   logic             alu_eq, alu_err;

   // Gating with rst_n keeps req_ready low for the whole reset assertion.
   assign can_issue = rst_n && ((slot_q == SLOT_EMPTY) || bus.rsp_ready);

   alu_rr_picker #(.NREQ(NREQ), .IW(SRCW)) u_picker (
      .en  (can_issue),
      .req (bus.req_valid),
      .ptr (rr_ptr_q),
      .gnt (gnt),
      .idx (gnt_idx),
      .any (issue)
   );

   assign bus.req_ready = gnt;

   // Operand mux feeding the single shared ALU.
   always_comb begin
      alu_a    = '0;
      alu_b    = '0;
      alu_ctrl = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) begin
            alu_a    = bus.req_op1[i*DW +: DW];
            alu_b    = bus.req_op2[i*DW +: DW];
            alu_ctrl = bus.req_ctrl[i*3 +: 3];
         end
      end
   end

   // The ALU itself; illegal codes yield zero data with the error flag.
   always_comb begin
      case (alu_ctrl)
         ADD:     alu_res = alu_a + alu_b;
         SUB:     alu_res = alu_a - alu_b;
         AND:     alu_res = alu_a & alu_b;
         OR:      alu_res = alu_a | alu_b;
         SLT:     alu_res = {{(DW-1){1'b0}}, ($signed(alu_a) < $signed(alu_b))};
         default: alu_res = '0;
      endcase
      alu_eq  = (alu_a == alu_b);
      alu_err = !is_legal_ctrl(alu_ctrl);
   end

   // Next state: capture on issue, otherwise drain or hold.
   always_comb begin
      slot_d     = slot_q;
      rsp_data_d = rsp_data_q;
      rsp_eq_d   = rsp_eq_q;
      rsp_err_d  = rsp_err_q;
      rsp_src_d  = rsp_src_q;
      rr_ptr_d   = rr_ptr_q;
      op_count_d = op_count_q;
      if (issue) begin
         slot_d     = SLOT_FULL;
         rsp_data_d = alu_res;
         rsp_eq_d   = alu_eq;
         rsp_err_d  = alu_err;
         rsp_src_d  = gnt_idx;
         rr_ptr_d   = (int'(gnt_idx) == NREQ - 1) ? '0 : gnt_idx + SRCW'(1);
         op_count_d = op_count_q + CNTW'(1);
      end else if (slot_q == SLOT_FULL && bus.rsp_ready) begin
         slot_d = SLOT_EMPTY;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_q     <= SLOT_EMPTY;
         rsp_data_q <= '0;
         rsp_eq_q   <= 1'b0;
         rsp_err_q  <= 1'b0;
         rsp_src_q  <= '0;
         rr_ptr_q   <= '0;
         op_count_q <= '0;
      end else begin
         slot_q     <= slot_d;
         rsp_data_q <= rsp_data_d;
         rsp_eq_q   <= rsp_eq_d;
         rsp_err_q  <= rsp_err_d;
         rsp_src_q  <= rsp_src_d;
         rr_ptr_q   <= rr_ptr_d;
         op_count_q <= op_count_d;
      end
   end

   assign bus.rsp_valid = (slot_q == SLOT_FULL);
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_eq    = rsp_eq_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_src   = rsp_src_q;
   assign bus.op_count  = op_count_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter, NREQ=2, DW=32, CNTW=16.
module tb_alu_share_arbiter;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   alu_share_arbiter_if #(.NREQ(2), .DW(32), .CNTW(16)) bus ();

   alu_share_arbiter #(.NREQ(2), .DW(32), .CNTW(16)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input logic r, input logic v, input logic [31:0] a,
                          input logic [31:0] b, input logic [2:0] c);
      if (r) begin
         bus.req_valid[1]    = v;
         bus.req_op1[63:32]  = a;
         bus.req_op2[63:32]  = b;
         bus.req_ctrl[5:3]   = c;
      end else begin
         bus.req_valid[0]    = v;
         bus.req_op1[31:0]   = a;
         bus.req_op2[31:0]   = b;
         bus.req_ctrl[2:0]   = c;
      end
   endtask

   task automatic chk_rsp(input string tag, input logic v, input logic [31:0] d,
                          input logic eq, input logic err, input logic src,
                          input logic [15:0] cnt);
      chk({tag, ".valid"}, 64'(bus.rsp_valid), 64'(v));
      chk({tag, ".data"},  64'(bus.rsp_data),  64'(d));
      chk({tag, ".eq"},    64'(bus.rsp_eq),    64'(eq));
      chk({tag, ".err"},   64'(bus.rsp_err),   64'(err));
      chk({tag, ".src"},   64'(bus.rsp_src),   64'(src));
      chk({tag, ".cnt"},   64'(bus.op_count),  64'(cnt));
   endtask

   initial begin
      logic [1:0] exp_gnt;
      logic       exp_src;
      logic [31:0] exp_data;
      n_chk  = 0;
      n_pass = 0;
      rst_n  = 1'b0;
      bus.req_valid = '0;
      bus.req_op1   = '0;
      bus.req_op2   = '0;
      bus.req_ctrl  = '0;
      bus.rsp_ready = 1'b1;

      // Reset: outputs zero, req_ready held low even with a valid request.
      set_req(1'b0, 1'b1, 32'd1, 32'd1, 3'b000);
      repeat (2) tick();
      chk_rsp("reset", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("reset.ready", 64'(bus.req_ready), 64'd0);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      rst_n = 1'b1;
      tick();

      // 1: single add from req0.
      set_req(1'b0, 1'b1, 32'd5, 32'd3, 3'b000);
      #1 chk("t1.ready", 64'(bus.req_ready), 64'b01);
      tick();
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      chk_rsp("t1", 1'b1, 32'd8, 1'b0, 1'b0, 1'b0, 16'd1);
      tick();
      chk("t1.drain", 64'(bus.rsp_valid), 64'd0);
      chk("t1.hold", 64'(bus.rsp_data), 64'd8);

      // 2: contention; pointer is 1 after req0 issued, so grants go 1,0,1,0.
      set_req(1'b0, 1'b1, 32'd10, 32'd4, 3'b001);
      set_req(1'b1, 1'b1, 32'h0000_00F0, 32'h0000_000F, 3'b011);
      for (int k = 0; k < 4; k++) begin
         exp_src  = (k % 2 == 0);
         exp_gnt  = exp_src ? 2'b10 : 2'b01;
         exp_data = exp_src ? 32'h0000_00FF : 32'd6;
         #1 chk("t2.ready", 64'(bus.req_ready), 64'(exp_gnt));
         tick();
         chk_rsp("t2", 1'b1, exp_data, 1'b0, 1'b0, exp_src, 16'(2 + k));
      end

      // 3: backpressure holds the slot (src0, data 6), then drain+refill.
      bus.rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1 chk("t3.ready", 64'(bus.req_ready), 64'd0);
         tick();
         chk_rsp("t3.hold", 1'b1, 32'd6, 1'b0, 1'b0, 1'b0, 16'd5);
      end
      bus.rsp_ready = 1'b1;
      #1 chk("t3.ready_rel", 64'(bus.req_ready), 64'b10);
      tick();
      chk_rsp("t3.refill", 1'b1, 32'h0000_00FF, 1'b0, 1'b0, 1'b1, 16'd6);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
      tick();
      chk("t3.empty", 64'(bus.rsp_valid), 64'd0);

      // 4: signed less-than, then subtract-to-zero with equality.
      set_req(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 3'b101);
      tick();
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      chk_rsp("t4.slt", 1'b1, 32'd1, 1'b0, 1'b0, 1'b0, 16'd7);
      set_req(1'b1, 1'b1, 32'd7, 32'd7, 3'b001);
      #1 chk("t4.ready", 64'(bus.req_ready), 64'b10);
      tick();
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
      chk_rsp("t4.sub", 1'b1, 32'd0, 1'b1, 1'b0, 1'b1, 16'd8);

      // 5: illegal control codes.
      set_req(1'b0, 1'b1, 32'd9, 32'd9, 3'b110);
      tick();
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      chk_rsp("t5.c110", 1'b1, 32'd0, 1'b1, 1'b1, 1'b0, 16'd9);
      set_req(1'b1, 1'b1, 32'd1, 32'd2, 3'b100);
      tick();
      chk_rsp("t5.c100", 1'b1, 32'd0, 1'b0, 1'b1, 1'b1, 16'd10);

      // 6: async reset while FULL with a handshake pending.
      set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'b000);
      set_req(1'b1, 1'b1, 32'd3, 32'd4, 3'b000);
      #1 chk("t6.ready_pre", 64'(bus.req_ready), 64'b01);
      #1 rst_n = 1'b0;
      #1;
      chk_rsp("t6.rst", 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 16'd0);
      chk("t6.ready_rst", 64'(bus.req_ready), 64'd0);
      set_req(1'b0, 1'b0, 32'd0, 32'd0, 3'b000);
      set_req(1'b1, 1'b0, 32'd0, 32'd0, 3'b000);
      #1 rst_n = 1'b1;
      tick();
      chk("t6.no_stale", 64'(bus.rsp_valid), 64'd0);
      set_req(1'b0, 1'b1, 32'd3, 32'd4, 3'b000);
      set_req(1'b1, 1'b1, 32'd3, 32'd4, 3'b000);
      #1 chk("t6.ptr0", 64'(bus.req_ready), 64'b01);
      tick();
      chk_rsp("t6.first", 1'b1, 32'd7, 1'b0, 1'b0, 1'b0, 16'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
